alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Sequencing stage wrapped around the combinational ALU. It holds the register file (REGS × DW), fetches and shifts operands, and drives the ALU's A, B and opcode inputs. It captures the ALU result and zero flag, then writes the result back. Requests arrive over a valid/ready handshake, one instruction per 4 cycles.

## Interface
- DW, 16, datapath width
- REGS, 8, register count; register index width RW = clog2(REGS)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction request
- in_ready  out  1  stage can accept a request
- in_op  in  2  ALU opcode, passed through to alu_op
- in_rn  in  RW  A-operand register
- in_rm  in  RW  B-operand register
- in_rd  in  RW  destination register
- in_shift  in  2  B shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
- in_use_imm  in  1  B = in_imm instead of shifted R[rm]
- in_imm  in  DW  immediate
- in_wb_en  in  1  write result to R[rd] (0 = flags only, compare)
- wr_ext_en  in  1  external register write
- wr_ext_reg  in  RW  external write index
- wr_ext_data  in  DW  external write data
- alu_ain  out  DW  to ALU A input (= A register)
- alu_bin  out  DW  to ALU B input (= B register)
- alu_op  out  2  to ALU opcode (= latched op)
- alu_out  in  DW  ALU result
- alu_z  in  1  ALU zero flag
- status_z  out  1  registered zero flag
- done  out  1  one-cycle pulse in WB
- dbg_sel  in  RW  debug read index
- dbg_data  out  DW  R[dbg_sel], combinational

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch op, rn, rm, rd, shift, use_imm, imm and wb_en, then go to READ.
  - READ: A ← R[rn]. B ← in_imm if use_imm, else shift(R[rm]). Go to EXEC.
  - EXEC: C ← alu_out and status_z ← alu_z. Go to WB.
  - WB: done=1. If wb_en, R[rd] ← C. Go to IDLE.
- in_ready is 1 only in IDLE. in_valid outside IDLE is ignored; upstream must hold the request until accepted.
- Shift rules:
  - The shift applies only to the register operand; the immediate is never shifted.
  - LSL1: {b[DW-2:0],0}.
  - LSR1: {0,b[DW-1:1]}.
  - ASR1: {b[DW-1],b[DW-1:1]}.
- All values are DW bits and wrap modulo 2^DW; the stage does no arithmetic beyond the shift.
- status_z updates in EXEC for every instruction, including wb_en=0. It holds at all other times.
- Register reads in READ see register contents as of that clock edge. A same-cycle external write is not forwarded.
- wr_ext_en is honoured in every state. If it coincides with a WB write to the same register, WB wins. If it targets a different register, both writes occur.
- in_rd = in_rn or in_rm is legal; the write happens after the operand capture.
- Reset (async assert, any state):
  - FSM goes to IDLE and in_ready=1.
  - All registers, A, B, C, latched op and status_z clear to 0.
  - done=0.
  - An in-flight instruction is discarded with no writeback.
- Reset deassertion is synchronous to clk. The first request can be accepted on the first rising edge after release.

## Timing
- Cycle T: in_valid && in_ready handshake.
- T+1: READ.
- T+2: EXEC, with alu_ain, alu_bin and alu_op stable for the whole cycle.
- T+3: WB and done=1. R[rd] is updated at the end of T+3.
- T+4: IDLE and in_ready=1, so back-to-back issue is every 4 cycles.
- A following instruction reading rd sees the new value, because its READ is at T+5 or later.
- status_z is visible from T+3.
- dbg_data reflects register writes on the cycle after the edge that performs them.

## Test plan
- After reset, external writes R1=0x0005 and R2=0x0003; ADD rn=1 rm=2 rd=3. Required: done at T+3, R3=0x0008, status_z=0.
- SUB rn=1 rm=1 rd=4, wb_en=0. Required: R4 unchanged (0), status_z=1.
- B shift: R2=0x8001.
  - LSL1 then NOT (op 11): R5=0xFFFD.
  - ASR1 then ADD with R0=0: R5=0xC000.
  - LSR1 then ADD with R0=0: R5=0x4000.
- Immediate: in_use_imm=1, in_imm=0x00F0, AND with R6=0x0FFF. Required: R7=0x00F0, and in_shift is ignored.
- Collision: wr_ext_en to R3 with data 0x1234 in the same cycle as WB to R3 (0x0008). Required: R3=0x0008.
- Reset mid-instruction: assert rst_n=0 during EXEC. Required: immediately in_ready=1, done=0, status_z=0; all registers 0 and no writeback.
- Handshake: hold in_valid for 6 cycles. Required: exactly one request accepted, and in_ready low for exactly 3 cycles.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: sequencer around an external combinational ALU.
// Holds the register file, fetches and shifts operands, feeds the ALU,
// captures its result and zero flag, and writes the result back.
// One instruction occupies the stage for four cycles: IDLE, READ, EXEC, WB.
//
// Handshake: a request transfers on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE. The requester
// must hold in_valid and the request fields stable until that edge;
// in_valid seen in any other state is ignored.
module alu_operand_stage #(
    parameter int DW   = 16,
    parameter int REGS = 8,
    localparam int RW  = (REGS > 1) ? $clog2(REGS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [RW-1:0] in_rn,
    input  logic [RW-1:0] in_rm,
    input  logic [RW-1:0] in_rd,
    input  logic [1:0]    in_shift,
    input  logic          in_use_imm,
    input  logic [DW-1:0] in_imm,
    input  logic          in_wb_en,
    input  logic          wr_ext_en,
    input  logic [RW-1:0] wr_ext_reg,
    input  logic [DW-1:0] wr_ext_data,
    output logic [DW-1:0] alu_ain,
    output logic [DW-1:0] alu_bin,
    output logic [1:0]    alu_op,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_z,
    output logic          status_z,
    output logic          done,
    input  logic [RW-1:0] dbg_sel,
    output logic [DW-1:0] dbg_data,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

    state_e        state_q;
    logic          in_ready_q;
    logic          done_q;

    // Latched request fields
    logic [1:0]    op_q;
    logic [RW-1:0] rn_q;
    logic [RW-1:0] rm_q;
    logic [RW-1:0] rd_q;
    logic [1:0]    shift_q;
    logic          use_imm_q;
    logic [DW-1:0] imm_q;
    logic          wb_en_q;

    // Operand, result and flag registers
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] c_q;
    logic          z_q;

    logic [DW-1:0] regs_q [REGS];

    logic [DW-1:0] rm_val;
    logic [DW-1:0] b_d;
    logic          wb_fire;

    // B operand: shifted R[rm], or the unshifted immediate when selected
    always_comb begin
        rm_val = regs_q[rm_q];
        b_d    = rm_val;
        case (shift_q)
            2'b01:   b_d = {rm_val[DW-2:0], 1'b0};
            2'b10:   b_d = {1'b0, rm_val[DW-1:1]};
            2'b11:   b_d = {rm_val[DW-1], rm_val[DW-1:1]};
            default: b_d = rm_val;
        endcase
        if (use_imm_q) begin
            b_d = imm_q;
        end
    end

    assign wb_fire = (state_q == S_WB) && wb_en_q;

    // Sequencer: latches the request, captures operands, result and flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            op_q       <= '0;
            rn_q       <= '0;
            rm_q       <= '0;
            rd_q       <= '0;
            shift_q    <= '0;
            use_imm_q  <= 1'b0;
            imm_q      <= '0;
            wb_en_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            z_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q       <= in_op;
                        rn_q       <= in_rn;
                        rm_q       <= in_rm;
                        rd_q       <= in_rd;
                        shift_q    <= in_shift;
                        use_imm_q  <= in_use_imm;
                        imm_q      <= in_imm;
                        wb_en_q    <= in_wb_en;
                        in_ready_q <= 1'b0;
                        state_q    <= S_READ;
                    end
                end
                S_READ: begin
                    // Reads see the pre-edge contents; a concurrent external
                    // write to the same register lands after the capture.
                    a_q     <= regs_q[rn_q];
                    b_q     <= b_d;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    c_q     <= alu_out;
                    z_q     <= alu_z;
                    done_q  <= 1'b1;
                    state_q <= S_WB;
                end
                S_WB: begin
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // Register file: external write first so a same-register writeback wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wr_ext_en) begin
                regs_q[wr_ext_reg] <= wr_ext_data;
            end
            if (wb_fire) begin
                regs_q[rd_q] <= c_q;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign done      = done_q;
    assign status_z  = z_q;
    assign alu_ain   = a_q;
    assign alu_bin   = b_q;
    assign alu_op    = op_q;
    assign dbg_data  = regs_q[dbg_sel];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, hand-written
// multi-cycle sequences, then randomized instructions against an
// arithmetic reference model of the register file and zero flag.
module tb_alu_operand_stage;

    localparam int DW   = 16;
    localparam int REGS = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [2:0]    in_rn, in_rm, in_rd;
    logic [1:0]    in_shift;
    logic          in_use_imm;
    logic [DW-1:0] in_imm;
    logic          in_wb_en;
    logic          wr_ext_en;
    logic [2:0]    wr_ext_reg;
    logic [DW-1:0] wr_ext_data;
    logic [DW-1:0] alu_ain, alu_bin, alu_out;
    logic [1:0]    alu_op;
    logic          alu_z;
    logic          status_z;
    logic          done;
    logic [2:0]    dbg_sel;
    logic [DW-1:0] dbg_data;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int ref_regs [REGS];
    int ref_z;

    typedef struct {
        int pre_reg;   // -1: no external write before the instruction
        int pre_data;
        int op, rn, rm, rd, shift, use_imm, imm, wb_en;
        int exp_rd;
        int exp_z;
    } vec_t;

    vec_t vecs [8];

    alu_operand_stage #(.DW(DW), .REGS(REGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
        .in_shift(in_shift), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .in_wb_en(in_wb_en),
        .wr_ext_en(wr_ext_en), .wr_ext_reg(wr_ext_reg), .wr_ext_data(wr_ext_data),
        .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op),
        .alu_out(alu_out), .alu_z(alu_z),
        .status_z(status_z), .done(done),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    // Clock / reset infrastructure
    always #50 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached (checks=%0d errors=%0d)", checks, errors);
        $fatal(1);
    end

    // Stand-in for the external ALU: 00 ADD, 01 SUB, 10 AND, 11 NOT B
    always_comb begin
        case (alu_op)
            2'b00:   alu_out = alu_ain + alu_bin;
            2'b01:   alu_out = alu_ain - alu_bin;
            2'b10:   alu_out = alu_ain & alu_bin;
            default: alu_out = ~alu_bin;
        endcase
        alu_z = (alu_out == '0);
    end

    // Reference model: result of one instruction from current model registers
    function automatic int ref_operate(input int op, input int rn, input int rm,
                                       input int shift, input int use_imm, input int imm);
        int a, r, b, res;
        a = ref_regs[rn];
        r = ref_regs[rm];
        if (use_imm != 0) b = imm;
        else begin
            case (shift)
                1:       b = (r * 2) % 65536;
                2:       b = r / 2;
                3:       b = r / 2 + ((r >= 32768) ? 32768 : 0);
                default: b = r;
            endcase
        end
        case (op)
            0:       res = (a + b) % 65536;
            1:       res = (a - b + 65536) % 65536;
            2:       res = a & b;
            default: res = 65535 - b;
        endcase
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string name, input int idx, input int exp);
        dbg_sel = 3'(idx);
        #1;
        check(name, 32'(dbg_data), exp);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < REGS; i++) begin
            check_reg($sformatf("%s_r%0d", tag, i), i, ref_regs[i]);
        end
    endtask

    task automatic ext_write(input int r, input int d);
        wr_ext_en   = 1'b1;
        wr_ext_reg  = 3'(r);
        wr_ext_data = 16'(d);
        step();
        wr_ext_en   = 1'b0;
        ref_regs[r] = d;
    endtask

    task automatic scramble_request();
        in_op      = 2'($urandom_range(0, 3));
        in_rn      = 3'($urandom_range(0, 7));
        in_rm      = 3'($urandom_range(0, 7));
        in_rd      = 3'($urandom_range(0, 7));
        in_shift   = 2'($urandom_range(0, 3));
        in_use_imm = 1'($urandom_range(0, 1));
        in_imm     = 16'($urandom_range(0, 65535));
        in_wb_en   = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_request(input int op, input int rn, input int rm, input int rd,
                                 input int shift, input int use_imm, input int imm, input int wb_en);
        in_op      = 2'(op);
        in_rn      = 3'(rn);
        in_rm      = 3'(rm);
        in_rd      = 3'(rd);
        in_shift   = 2'(shift);
        in_use_imm = 1'(use_imm);
        in_imm     = 16'(imm);
        in_wb_en   = 1'(wb_en);
    endtask

    // Driver: one full instruction, optional external write in cycle T+ext_cyc
    task automatic run_instr(input string tag, input int op, input int rn, input int rm,
                             input int rd, input int shift, input int use_imm, input int imm,
                             input int wb_en, input int ext_cyc, input int ext_reg,
                             input int ext_data);
        int res, lat, low_n, z_at_done, wait_n;
        wait_n = 0;
        while (!in_ready && wait_n < 8) begin
            step();
            wait_n++;
        end
        check($sformatf("%s_ready", tag), 32'(in_ready), 1);
        res = ref_operate(op, rn, rm, shift, use_imm, imm);
        drive_request(op, rn, rm, rd, shift, use_imm, imm, wb_en);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        scramble_request();
        lat = 0;
        low_n = 0;
        z_at_done = 0;
        for (int c = 1; c <= 8; c++) begin
            if (!in_ready) low_n++;
            if (done) begin
                lat = c;
                z_at_done = int'(status_z);
            end
            wr_ext_en   = (c == ext_cyc);
            wr_ext_reg  = 3'(ext_reg);
            wr_ext_data = 16'(ext_data);
            step();
            wr_ext_en = 1'b0;
            if (lat != 0) break;
        end
        if (ext_cyc >= 1 && ext_cyc <= 3) ref_regs[ext_reg] = ext_data;
        if (wb_en != 0) ref_regs[rd] = res;
        ref_z = (res == 0) ? 1 : 0;
        check($sformatf("%s_done_latency", tag), lat, 3);
        check($sformatf("%s_busy_cycles", tag), low_n, 3);
        check($sformatf("%s_z_at_done", tag), z_at_done, ref_z);
        check($sformatf("%s_ready_after", tag), 32'(in_ready), 1);
        check($sformatf("%s_z_hold", tag), 32'(status_z), ref_z);
        check_reg($sformatf("%s_rd", tag), rd, ref_regs[rd]);
    endtask

    initial begin
        int accepts, low_before, low_after, acc_seen, done_seen;

        // Directed vectors: {pre_reg, pre_data, op, rn, rm, rd, shift, use_imm, imm, wb_en, exp_rd, exp_z}
        vecs[0] = '{-1, 0,       0, 1, 2, 3, 0, 0, 0,       1, 'h0008, 0}; // ADD 5+3
        vecs[1] = '{-1, 0,       1, 1, 1, 4, 0, 0, 0,       0, 'h0000, 1}; // SUB compare only
        vecs[2] = '{ 2, 'h8001,  3, 0, 2, 5, 1, 0, 0,       1, 'hFFFD, 0}; // LSL1 then NOT
        vecs[3] = '{-1, 0,       0, 0, 2, 5, 3, 0, 0,       1, 'hC000, 0}; // ASR1 + R0
        vecs[4] = '{-1, 0,       0, 0, 2, 5, 2, 0, 0,       1, 'h4000, 0}; // LSR1 + R0
        vecs[5] = '{ 6, 'h0FFF,  2, 6, 2, 7, 1, 1, 'h00F0,  1, 'h00F0, 0}; // AND imm, shift ignored
        vecs[6] = '{-1, 0,       0, 1, 1, 1, 0, 0, 0,       1, 'h000A, 0}; // rd == rn == rm
        vecs[7] = '{ 4, 'hFFFF,  3, 0, 4, 4, 0, 0, 0,       1, 'h0000, 1}; // NOT to zero, rd == rm

        rst_n = 1'b0;
        in_valid = 1'b0;
        drive_request(0, 0, 0, 0, 0, 0, 0, 0);
        wr_ext_en = 1'b0;
        wr_ext_reg = '0;
        wr_ext_data = '0;
        dbg_sel = '0;
        ref_z = 0;
        for (int i = 0; i < REGS; i++) ref_regs[i] = 0;

        // Reset state
        repeat (2) step();
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_done", 32'(done), 0);
        check("reset_status_z", 32'(status_z), 0);
        check_regs("reset");
        rst_n = 1'b1;

        ext_write(1, 'h0005);
        ext_write(2, 'h0003);

        // Table-driven directed vectors
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].pre_reg >= 0) ext_write(vecs[v].pre_reg, vecs[v].pre_data);
            run_instr($sformatf("vec%0d", v), vecs[v].op, vecs[v].rn, vecs[v].rm, vecs[v].rd,
                      vecs[v].shift, vecs[v].use_imm, vecs[v].imm, vecs[v].wb_en, 0, 0, 0);
            check_reg($sformatf("vec%0d_exp_rd", v), vecs[v].rd, vecs[v].exp_rd);
            check($sformatf("vec%0d_exp_z", v), 32'(status_z), vecs[v].exp_z);
        end
        check_regs("table");

        // Collision: external write and writeback to R3 in the same WB cycle
        ext_write(3, 'h7777);
        run_instr("collide", 0, 0, 0, 3, 0, 1, 'h0008, 1, 3, 3, 'h1234);
        check_reg("collide_r3", 3, 'h0008);

        // Different targets in WB: both writes land
        run_instr("both", 0, 0, 0, 2, 0, 1, 'h0042, 1, 3, 4, 'h5555);
        check_reg("both_r2", 2, 'h0042);
        check_reg("both_r4", 4, 'h5555);

        // External write during READ to the A source is not forwarded
        run_instr("nofwd", 0, 6, 0, 7, 0, 1, 'h0000, 1, 1, 6, 'h1111);
        check_reg("nofwd_r7", 7, 'h0FFF);
        check_reg("nofwd_r6", 6, 'h1111);

        // Reset in EXEC: set status_z first so its clearing is visible
        run_instr("presetz", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_request(0, 1, 1, 1, 0, 0, 0, 1);
        in_valid = 1'b1;
        check("rst_seq_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        step();
        check("rst_seq_z_before", 32'(status_z), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", 32'(in_ready), 1);
        check("rst_mid_done", 32'(done), 0);
        check("rst_mid_status_z", 32'(status_z), 0);
        check("rst_mid_alu_ain", 32'(alu_ain), 0);
        for (int i = 0; i < REGS; i++) ref_regs[i] = 0;
        ref_z = 0;
        check_regs("rst_mid");
        #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (done) done_seen = 1;
        end
        check("rst_no_done", done_seen, 0);
        check_regs("rst_after");

        // Handshake: request held for 6 cycles while the stage is busy
        ext_write(1, 'h0005);
        ext_write(2, 'h0003);
        drive_request(0, 1, 2, 3, 0, 0, 0, 1);
        in_valid = 1'b1;
        check("hs_ready0", 32'(in_ready), 1);
        step();
        drive_request(1, 1, 2, 4, 0, 0, 0, 1);
        accepts = 0;
        low_before = 0;
        low_after = 0;
        acc_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (in_ready) begin
                accepts++;
                acc_seen = 1;
            end else if (acc_seen != 0) low_after++;
            else low_before++;
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !in_ready; k++) begin
            low_after++;
            step();
        end
        ref_regs[3] = 'h0008;
        ref_regs[4] = 'h0002;
        ref_z = 0;
        check("hs_accepts", accepts, 1);
        check("hs_low_before", low_before, 3);
        check("hs_low_after", low_after, 3);
        check("hs_status_z", 32'(status_z), 0);
        check_regs("hs");

        // Randomized instructions against the reference model
        for (int i = 0; i < REGS; i++) ext_write(i, int'($urandom_range(0, 65535)));
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                ext_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
            run_instr($sformatf("rnd%0d", n),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 65535)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 65535)));
            check_regs($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
